// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Constants and helpers shared by the FIFO and its read-side
//                arbiter, so both agree on word width and read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   localparam int DEF_FIFO_DATA_WIDTH = 8;
   localparam int DEF_LATENCY         = 3;

   // Number of bits needed to encode value distinct indices (minimum 1).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_arbiter_if
//  Description : Consumer-side and FIFO-side signals of the read arbiter.
//                master = arbiter view, slave = consumers plus FIFO view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_read_arbiter_if #(
   parameter int N_REQ           = 4,
   parameter int FIFO_DATA_WIDTH = fifo_pkg::DEF_FIFO_DATA_WIDTH
);

   logic                       enable;
   logic [N_REQ-1:0]           req;
   logic [N_REQ-1:0]           req_mask;
   logic [N_REQ-1:0]           gnt;
   logic                       fifo_read;
   logic                       fifo_empty;
   logic [FIFO_DATA_WIDTH-1:0] fifo_read_data;
   logic [N_REQ-1:0]           rsp_valid;
   logic [FIFO_DATA_WIDTH-1:0] rsp_data;
   logic                       busy;

   modport master (
      input  enable, req, req_mask, fifo_empty, fifo_read_data,
      output gnt, fifo_read, rsp_valid, rsp_data, busy
   );

   modport slave (
      output enable, req, req_mask, fifo_empty, fifo_read_data,
      input  gnt, fifo_read, rsp_valid, rsp_data, busy
   );

endinterface
`default_nettype wire

// File: rtl/fifo_read_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin picker. Scans elig starting at the pointer,
//                produces a one-hot grant plus its encoded index, and moves
//                the pointer just past the winner when the grant is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  wire logic           clk,
   input  wire logic           reset,
   input  wire logic           en_i,
   input  wire logic [N-1:0]   elig_i,
   output logic      [N-1:0]   gnt_o,
   output logic      [IDW-1:0] gnt_id_o
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;
   logic           found_w;
   logic [IDW-1:0] pick_w;
   logic [IDW-1:0] scan_id_w;
   int             scan_w;

   // Find the first eligible index at or after the pointer, wrapping at N.
   always_comb begin
      found_w   = 1'b0;
      pick_w    = '0;
      scan_w    = 0;
      scan_id_w = '0;
      for (int off = 0; off < N; off++) begin
         scan_w = int'(ptr_q) + off;
         if (scan_w >= N) begin
            scan_w = scan_w - N;
         end
         scan_id_w = IDW'(scan_w);
         if (!found_w && elig_i[scan_id_w]) begin
            found_w = 1'b1;
            pick_w  = scan_id_w;
         end
      end
   end

   // Grant only when the read is actually issued; advance pointer past winner.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = pick_w;
      ptr_d    = ptr_q;
      if (en_i && found_w) begin
         gnt_o = N'(1) << pick_w;
         if (pick_w == IDW'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = pick_w + IDW'(1);
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_arbiter
//  Description : Shares one FIFO read port among N_REQ consumers. Issues one
//                read per cycle for the round-robin winner, carries the
//                winner's id through a LATENCY-deep tag pipe and returns the
//                word with a one-hot valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter
   import fifo_pkg::*;
#(
   parameter int N_REQ           = 4,
   parameter int FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
   parameter int LATENCY         = DEF_LATENCY
) (
   input  wire logic           clk,
   input  wire logic           reset,
   fifo_read_arbiter_if.master bus
);

   localparam int ID_WIDTH = clog2(N_REQ);

   logic [N_REQ-1:0]                  elig_w;
   logic                              fifo_read_w;
   logic [N_REQ-1:0]                  gnt_w;
   logic [ID_WIDTH-1:0]               gnt_id_w;

   logic [LATENCY-1:0]                tag_vld_q;
   logic [LATENCY-1:0]                tag_vld_d;
   logic [LATENCY-1:0][ID_WIDTH-1:0]  tag_id_q;
   logic [LATENCY-1:0][ID_WIDTH-1:0]  tag_id_d;
   logic [N_REQ-1:0]                  rsp_valid_q;
   logic [N_REQ-1:0]                  rsp_valid_d;
   logic [FIFO_DATA_WIDTH-1:0]        rsp_data_q;
   logic [FIFO_DATA_WIDTH-1:0]        rsp_data_d;

   // Reset gates the strobe so nothing is popped while the pipe is held clear.
   assign elig_w      = bus.req & ~bus.req_mask;
   assign fifo_read_w = bus.enable & ~bus.fifo_empty & (|elig_w) & ~reset;

   rr_arbiter #(
      .N   (N_REQ),
      .IDW (ID_WIDTH)
   ) u_rr_arbiter (
      .clk      (clk),
      .reset    (reset),
      .en_i     (fifo_read_w),
      .elig_i   (elig_w),
      .gnt_o    (gnt_w),
      .gnt_id_o (gnt_id_w)
   );

   // Shift the owner tags alongside the FIFO latency; capture data at the tail.
   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = fifo_read_w;
      tag_id_d[0]  = gnt_id_w;
      for (int s = 1; s < LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (tag_vld_q[LATENCY-1]) begin
         rsp_valid_d = N_REQ'(1) << tag_id_q[LATENCY-1];
         rsp_data_d  = bus.fifo_read_data;
      end
   end

   // Tag pipe and response registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign bus.gnt       = gnt_w;
   assign bus.fifo_read = fifo_read_w;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = |tag_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_arbiter
//  Description : Bench for fifo_read_arbiter with a behavioural FIFO, a
//                round-robin reference model feeding a scoreboard queue and
//                an independent response monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int L = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fifo_read_arbiter_if #(.N_REQ(N), .FIFO_DATA_WIDTH(W)) bus ();

   fifo_read_arbiter #(
      .N_REQ           (N),
      .FIFO_DATA_WIDTH (W),
      .LATENCY         (L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      int         id;
      logic [W-1:0] data;
   } exp_t;

   logic [W-1:0] fifoq[$];
   logic [W-1:0] sched[int];
   exp_t         expq[$];
   logic         last_rd   = 1'b0;
   int           m_ptr     = 0;
   logic [W-1:0] last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Behavioural FIFO: a read seen in cycle t pops the head and presents it in cycle t+L.
   initial begin
      bus.fifo_empty     = 1'b1;
      bus.fifo_read_data = '0;
      forever begin
         @(posedge clk);
         #2;
         if (last_rd && fifoq.size() > 0) begin
            sched[cyc - 1 + L] = fifoq.pop_front();
         end
         if (sched.exists(cyc)) begin
            bus.fifo_read_data = sched[cyc];
            sched.delete(cyc);
         end else begin
            bus.fifo_read_data = W'($urandom);
         end
         bus.fifo_empty = (fifoq.size() == 0);
      end
   end

   // Reference model: round-robin over eligible consumers, pushes expected responses.
   always @(negedge clk) begin
      logic [N-1:0] elig;
      logic [N-1:0] exp_gnt;
      logic         exp_rd;
      logic         found;
      int           k;
      int           c;
      last_rd = bus.fifo_read;
      if (reset) begin
         expq.delete();
         m_ptr = 0;
         check("gnt_in_reset", 32'(bus.gnt), 32'(0));
         check("rd_in_reset", 32'(bus.fifo_read), 32'(0));
      end else begin
         elig    = bus.req & ~bus.req_mask;
         exp_rd  = bus.enable && (fifoq.size() > 0) && (elig != '0);
         exp_gnt = '0;
         if (exp_rd) begin
            found = 1'b0;
            k     = 0;
            for (int i = 0; i < N; i++) begin
               c = (m_ptr + i) % N;
               if (!found && elig[c]) begin
                  found = 1'b1;
                  k     = c;
               end
            end
            exp_gnt = N'(1) << k;
            expq.push_back('{due: cyc + L + 1, id: k, data: fifoq[0]});
            m_ptr = (k + 1) % N;
         end
         check("fifo_read", 32'(bus.fifo_read), 32'(exp_rd));
         check("gnt", 32'(bus.gnt), 32'(exp_gnt));
      end
   end

   // Monitor: matches every presented response against the scoreboard.
   always @(negedge clk) begin
      logic         eb;
      logic [N-1:0] oh;
      if (reset) begin
         last_data = '0;
         check("rsp_valid_in_reset", 32'(bus.rsp_valid), 32'(0));
         check("busy_in_reset", 32'(bus.busy), 32'(0));
      end else begin
         while (expq.size() > 0 && expq[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_lost cycle %0d: got none expected id %0d data %0h due %0d",
                     cyc, expq[0].id, expq[0].data, expq[0].due);
            void'(expq.pop_front());
         end
         if (expq.size() > 0 && expq[0].due == cyc) begin
            oh = N'(1) << expq[0].id;
            check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
            check("rsp_data", 32'(bus.rsp_data), 32'(expq[0].data));
            last_data = expq[0].data;
            void'(expq.pop_front());
         end else begin
            check("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
            check("rsp_data_hold", 32'(bus.rsp_data), 32'(last_data));
         end
         eb = 1'b0;
         foreach (expq[i]) begin
            if (expq[i].due > cyc && expq[i].due <= cyc + L) eb = 1'b1;
         end
         check("busy", 32'(bus.busy), 32'(eb));
      end
   end

   initial begin
      bus.enable   = 1'b0;
      bus.req      = '0;
      bus.req_mask = '0;
      reset        = 1'b1;
      tick(3);
      check("rsp_data_reset", 32'(bus.rsp_data), 32'(0));
      reset = 1'b0;

      // Four consumers share eight words.
      for (int i = 0; i < 8; i++) fifoq.push_back(W'(i));
      bus.enable = 1'b1;
      bus.req    = 4'b1111;
      tick(14);
      bus.req = '0;
      tick(4);

      // Single word, single consumer, then idle on empty.
      fifoq.push_back(8'h55);
      bus.req = 4'b0001;
      tick(8);

      // Requests waiting on an empty FIFO, words trickle in.
      bus.req = 4'b0110;
      tick(4);
      for (int i = 0; i < 3; i++) begin
         fifoq.push_back(W'(8'h30 + i));
         tick(1);
      end
      tick(8);

      // Masked consumers never granted.
      bus.req      = 4'b1111;
      bus.req_mask = 4'b0101;
      for (int i = 0; i < 6; i++) fifoq.push_back(W'(8'h40 + i));
      tick(12);
      bus.req_mask = '0;
      bus.req      = '0;
      tick(2);

      // Enable dropped mid-burst.
      for (int i = 0; i < 10; i++) fifoq.push_back(W'(8'h60 + i));
      bus.req = 4'b1111;
      tick(3);
      bus.enable = 1'b0;
      tick(6);
      bus.enable = 1'b1;
      tick(10);
      bus.req = '0;
      tick(2);

      // Reset with reads in flight.
      for (int i = 0; i < 10; i++) fifoq.push_back(W'(8'h80 + i));
      bus.req = 4'b1111;
      tick(4);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(12);
      bus.req = '0;
      tick(5);

      // Randomized traffic with occasional masking, enable drops and resets.
      for (int n = 0; n < 400; n++) begin
         bus.req      = N'($urandom);
         bus.req_mask = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         bus.enable   = ($urandom_range(9) != 0);
         if ($urandom_range(4) < 2) fifoq.push_back(W'($urandom));
         if ($urandom_range(9) == 0) fifoq.push_back(W'($urandom));
         reset = ($urandom_range(149) == 0);
         tick(1);
      end
      reset   = 1'b0;
      bus.req = '0;

      for (int i = 0; i < 50 && expq.size() > 0; i++) tick(1);
      if (expq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending responses expected 0", expq.size());
      end
      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
